// File: rtl/bp_fe_imem_responder_if.sv
// Fetch command/response bundle between the FE PC generator (master) and the imem responder (slave).
// Also carries the boot/bench preload write port into the responder's instruction array.
interface bp_fe_imem_responder_if #(
    parameter int vaddr_width_p       = 39,
    parameter int paddr_width_p       = 40,
    parameter int page_offset_width_p = 12,
    parameter int mem_words_p         = 1024
);
    localparam int vtag_width_lp     = vaddr_width_p - page_offset_width_p;
    localparam int ptag_width_lp     = paddr_width_p - page_offset_width_p;
    localparam int mem_addr_width_lp = $clog2(mem_words_p);

    logic                         mem_cmd_v;
    logic [1:0]                   mem_cmd_op;
    logic [vaddr_width_p-1:0]     mem_cmd_vaddr;
    logic [vtag_width_lp-1:0]     mem_cmd_vtag;
    logic [ptag_width_lp-1:0]     mem_cmd_ptag;
    logic                         mem_cmd_u;
    logic                         mem_cmd_x;
    logic                         mem_cmd_yumi;
    logic [1:0]                   mem_priv;
    logic                         mem_translation_en;
    logic                         mem_poison;

    logic                         mem_resp_v;
    logic [31:0]                  resp_data;
    logic                         resp_icache_miss;
    logic                         resp_itlb_miss;
    logic                         resp_access_fault;
    logic                         resp_page_fault;

    logic                         mem_w_v;
    logic [mem_addr_width_lp-1:0] mem_w_addr;
    logic [31:0]                  mem_w_data;

    modport master (
        output mem_cmd_v, mem_cmd_op, mem_cmd_vaddr, mem_cmd_vtag, mem_cmd_ptag, mem_cmd_u, mem_cmd_x,
        output mem_priv, mem_translation_en, mem_poison, mem_w_v, mem_w_addr, mem_w_data,
        input  mem_cmd_yumi, mem_resp_v, resp_data, resp_icache_miss, resp_itlb_miss,
        input  resp_access_fault, resp_page_fault
    );

    modport slave (
        input  mem_cmd_v, mem_cmd_op, mem_cmd_vaddr, mem_cmd_vtag, mem_cmd_ptag, mem_cmd_u, mem_cmd_x,
        input  mem_priv, mem_translation_en, mem_poison, mem_w_v, mem_w_addr, mem_w_data,
        output mem_cmd_yumi, mem_resp_v, resp_data, resp_icache_miss, resp_itlb_miss,
        output resp_access_fault, resp_page_fault
    );
endinterface

// File: rtl/bp_fe_imem_responder.sv
// Target side of the FE fetch interface: small fully-associative ITLB, local instruction array,
// two-stage fetch pipeline with poison, and periodic injected icache misses that stall acceptance.
module bp_fe_imem_responder #(
    parameter int vaddr_width_p       = 39,
    parameter int paddr_width_p       = 40,
    parameter int page_offset_width_p = 12,
    parameter int itlb_els_p          = 8,
    parameter int mem_words_p         = 1024,
    parameter int miss_period_p       = 0,
    parameter int miss_latency_p      = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bp_fe_imem_responder_if.slave   fe_if
);
    localparam int vtag_width_lp     = vaddr_width_p - page_offset_width_p;
    localparam int ptag_width_lp     = paddr_width_p - page_offset_width_p;
    localparam int mem_addr_width_lp = $clog2(mem_words_p);
    localparam int ptr_width_lp      = $clog2(itlb_els_p);

    localparam logic [1:0] op_fetch_lp   = 2'd0;
    localparam logic [1:0] op_fill_lp    = 2'd1;
    localparam logic [1:0] op_fence_lp   = 2'd2;
    localparam logic [1:0] priv_user_lp  = 2'd0;
    localparam logic [1:0] priv_super_lp = 2'd1;

    typedef enum logic {e_ready, e_miss} state_e;

    state_e                    state_q, state_d;
    logic [31:0]               lat_q, lat_d;
    logic [31:0]               miss_cnt_q, miss_cnt_d;

    logic                      s1_v_q, s1_v_d;
    logic [vaddr_width_p-1:0]  s1_vaddr_q, s1_vaddr_d;
    logic [1:0]                s1_priv_q, s1_priv_d;
    logic                      s1_tr_en_q, s1_tr_en_d;

    logic                      resp_v_q, resp_v_d;
    logic [31:0]               resp_data_q, resp_data_d;
    logic                      icm_q, icm_d, itlbm_q, itlbm_d, af_q, af_d, pf_q, pf_d;

    logic [itlb_els_p-1:0]     tlb_v_q, tlb_v_d, tlb_u_q, tlb_u_d, tlb_x_q, tlb_x_d;
    logic [vtag_width_lp-1:0]  tlb_vtag_q [itlb_els_p];
    logic [vtag_width_lp-1:0]  tlb_vtag_d [itlb_els_p];
    logic [ptag_width_lp-1:0]  tlb_ptag_q [itlb_els_p];
    logic [ptag_width_lp-1:0]  tlb_ptag_d [itlb_els_p];
    logic [ptr_width_lp-1:0]   ptr_q, ptr_d;

    logic [31:0]               mem_q [mem_words_p];

    logic                      cmd_yumi;
    logic                      hit, s1_itlb_miss, s1_page_fault, s1_access_fault, s1_live;
    logic [ptr_width_lp-1:0]   hit_idx, match_idx, free_idx, fill_idx;
    logic                      fill_match, fill_free;
    logic [paddr_width_p-1:0]  paddr;

    // Instruction array has no reset; a same-cycle preload write is seen by stage1 only next cycle.
    always_ff @(posedge clk_i) begin
        if (fe_if.mem_w_v) begin
            mem_q[fe_if.mem_w_addr] <= fe_if.mem_w_data;
        end
    end

    assign cmd_yumi           = fe_if.mem_cmd_v & (state_q == e_ready) & ~reset_i;
    assign fe_if.mem_cmd_yumi = cmd_yumi;
    assign s1_live            = s1_v_q & ~fe_if.mem_poison;

    // Stage1 translation; fault flags are made mutually exclusive by priority here.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < itlb_els_p; i++) begin
            if (tlb_v_q[i] && tlb_vtag_q[i] == s1_vaddr_q[vaddr_width_p-1:page_offset_width_p]) begin
                hit     = 1'b1;
                hit_idx = ptr_width_lp'(i);
            end
        end
        paddr = s1_tr_en_q ? {tlb_ptag_q[hit_idx], s1_vaddr_q[page_offset_width_p-1:0]}
                           : paddr_width_p'(s1_vaddr_q);
        s1_itlb_miss    = s1_tr_en_q & ~hit;
        s1_page_fault   = ~s1_itlb_miss & s1_tr_en_q &
                          (~tlb_x_q[hit_idx] | ((s1_priv_q == priv_user_lp) & ~tlb_u_q[hit_idx]) |
                           ((s1_priv_q == priv_super_lp) & tlb_u_q[hit_idx]));
        s1_access_fault = ~s1_itlb_miss & ~s1_page_fault & (paddr >= paddr_width_p'(4 * mem_words_p));
    end

    always_comb begin
        resp_v_d    = s1_live;
        resp_data_d = '0;
        icm_d       = 1'b0;
        itlbm_d     = 1'b0;
        af_d        = 1'b0;
        pf_d        = 1'b0;
        miss_cnt_d  = miss_cnt_q;
        state_d     = state_q;
        lat_d       = lat_q;
        if (state_q == e_miss) begin
            if (lat_q <= 32'd1) begin
                state_d = e_ready;
                lat_d   = '0;
            end else begin
                lat_d = lat_q - 32'd1;
            end
        end
        if (s1_live) begin
            itlbm_d = s1_itlb_miss;
            pf_d    = s1_page_fault;
            af_d    = s1_access_fault;
            if (!(s1_itlb_miss || s1_page_fault || s1_access_fault)) begin
                if ((miss_period_p != 0) && (miss_cnt_q == 32'(miss_period_p - 1))) begin
                    icm_d      = 1'b1;
                    miss_cnt_d = '0;
                    state_d    = e_miss;
                    lat_d      = 32'(miss_latency_p);
                end else begin
                    resp_data_d = mem_q[paddr[2 +: mem_addr_width_lp]];
                    miss_cnt_d  = miss_cnt_q + 32'd1;
                end
            end
        end
        s1_v_d     = cmd_yumi & (fe_if.mem_cmd_op == op_fetch_lp);
        s1_vaddr_d = cmd_yumi ? fe_if.mem_cmd_vaddr : s1_vaddr_q;
        s1_priv_d  = cmd_yumi ? fe_if.mem_priv : s1_priv_q;
        s1_tr_en_d = cmd_yumi ? fe_if.mem_translation_en : s1_tr_en_q;
    end

    // Fill target: existing match, else lowest invalid entry, else round-robin victim.
    always_comb begin
        tlb_v_d    = tlb_v_q;
        tlb_u_d    = tlb_u_q;
        tlb_x_d    = tlb_x_q;
        tlb_vtag_d = tlb_vtag_q;
        tlb_ptag_d = tlb_ptag_q;
        ptr_d      = ptr_q;
        fill_match = 1'b0;
        fill_free  = 1'b0;
        match_idx  = '0;
        free_idx   = '0;
        fill_idx   = '0;
        for (int i = itlb_els_p - 1; i >= 0; i--) begin
            if (tlb_v_q[i] && tlb_vtag_q[i] == fe_if.mem_cmd_vtag) begin
                fill_match = 1'b1;
                match_idx  = ptr_width_lp'(i);
            end
            if (!tlb_v_q[i]) begin
                fill_free = 1'b1;
                free_idx  = ptr_width_lp'(i);
            end
        end
        if (cmd_yumi && fe_if.mem_cmd_op == op_fill_lp) begin
            if (fill_match) begin
                fill_idx = match_idx;
            end else if (fill_free) begin
                fill_idx = free_idx;
            end else begin
                fill_idx = ptr_q;
                ptr_d    = ptr_q + ptr_width_lp'(1);
            end
            tlb_v_d[fill_idx]    = 1'b1;
            tlb_u_d[fill_idx]    = fe_if.mem_cmd_u;
            tlb_x_d[fill_idx]    = fe_if.mem_cmd_x;
            tlb_vtag_d[fill_idx] = fe_if.mem_cmd_vtag;
            tlb_ptag_d[fill_idx] = fe_if.mem_cmd_ptag;
        end else if (cmd_yumi && fe_if.mem_cmd_op == op_fence_lp) begin
            tlb_v_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= e_ready;
            lat_q       <= '0;
            miss_cnt_q  <= '0;
            s1_v_q      <= 1'b0;
            s1_vaddr_q  <= '0;
            s1_priv_q   <= '0;
            s1_tr_en_q  <= 1'b0;
            resp_v_q    <= 1'b0;
            resp_data_q <= '0;
            icm_q       <= 1'b0;
            itlbm_q     <= 1'b0;
            af_q        <= 1'b0;
            pf_q        <= 1'b0;
            tlb_v_q     <= '0;
            tlb_u_q     <= '0;
            tlb_x_q     <= '0;
            ptr_q       <= '0;
            for (int i = 0; i < itlb_els_p; i++) begin
                tlb_vtag_q[i] <= '0;
                tlb_ptag_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            miss_cnt_q  <= miss_cnt_d;
            s1_v_q      <= s1_v_d;
            s1_vaddr_q  <= s1_vaddr_d;
            s1_priv_q   <= s1_priv_d;
            s1_tr_en_q  <= s1_tr_en_d;
            resp_v_q    <= resp_v_d;
            resp_data_q <= resp_data_d;
            icm_q       <= icm_d;
            itlbm_q     <= itlbm_d;
            af_q        <= af_d;
            pf_q        <= pf_d;
            tlb_v_q     <= tlb_v_d;
            tlb_u_q     <= tlb_u_d;
            tlb_x_q     <= tlb_x_d;
            ptr_q       <= ptr_d;
            tlb_vtag_q  <= tlb_vtag_d;
            tlb_ptag_q  <= tlb_ptag_d;
        end
    end

    assign fe_if.mem_resp_v        = resp_v_q;
    assign fe_if.resp_data         = resp_data_q;
    assign fe_if.resp_icache_miss  = icm_q;
    assign fe_if.resp_itlb_miss    = itlbm_q;
    assign fe_if.resp_access_fault = af_q;
    assign fe_if.resp_page_fault   = pf_q;

endmodule

// File: tb/tb_bp_fe_imem_responder.sv
// Randomized bench for bp_fe_imem_responder against a transaction-level model of the
// fetch/fill/fence rules, plus directed sequences for the named corner cases.
module tb_bp_fe_imem_responder;
    localparam int VW    = 39;
    localparam int PW    = 40;
    localparam int MEMW  = 1024;
    localparam int ELS   = 8;
    localparam int MISSP = 3;
    localparam int MISSL = 4;
    localparam logic [1:0] OP_FETCH = 2'd0, OP_FILL = 2'd1, OP_FENCE = 2'd2;
    localparam logic [1:0] PRIV_U = 2'd0, PRIV_S = 2'd1;

    typedef struct packed {
        logic [31:0] data;
        logic        icm;
        logic        itlbm;
        logic        af;
        logic        pf;
    } resp_t;

    logic clk;
    logic rst;

    bp_fe_imem_responder_if #(.vaddr_width_p(VW), .paddr_width_p(PW), .page_offset_width_p(12),
                              .mem_words_p(MEMW)) fe_if ();

    bp_fe_imem_responder #(
        .vaddr_width_p(VW), .paddr_width_p(PW), .page_offset_width_p(12), .itlb_els_p(ELS),
        .mem_words_p(MEMW), .miss_period_p(MISSP), .miss_latency_p(MISSL)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .fe_if   (fe_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: memory image, ITLB contents, pipeline slots, miss bookkeeping.
    logic [31:0] mem_m [MEMW];
    bit          tv [ELS];
    logic [26:0] tvt [ELS];
    logic [27:0] tpt [ELS];
    bit          tu [ELS];
    bit          tx [ELS];
    int          rr;
    bit          s1v;
    logic [38:0] s1va;
    logic [1:0]  s1pr;
    bit          s1tr;
    bit          s2v;
    resp_t       s2r;
    int          clean_cnt;
    int          cycle;
    int          miss_start;
    int          miss_end;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got=%h expected=%h", tag, cycle, obs, exp);
        end
    endtask

    function automatic int tlbFind(input logic [26:0] vt);
        for (int i = 0; i < ELS; i++) begin
            if (tv[i] && tvt[i] == vt) return i;
        end
        return -1;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < ELS; i++) tv[i] = 1'b0;
        rr = 0; s1v = 0; s2v = 0; s2r = '0; clean_cnt = 0;
        miss_start = 1; miss_end = 0;
    endtask

    task automatic modelFill(input logic [26:0] vt, input logic [27:0] pt, input bit u, input bit x);
        int idx;
        idx = tlbFind(vt);
        if (idx < 0) begin
            for (int i = ELS - 1; i >= 0; i--) if (!tv[i]) idx = i;
        end
        if (idx < 0) begin
            idx = rr;
            rr  = (rr + 1) % ELS;
        end
        tv[idx] = 1'b1; tvt[idx] = vt; tpt[idx] = pt; tu[idx] = u; tx[idx] = x;
    endtask

    task automatic applyStimulus(input bit cv, input logic [1:0] op, input logic [38:0] va,
                                 input logic [26:0] vt, input logic [27:0] pt, input bit u, input bit x,
                                 input logic [1:0] pr, input bit tr, input bit poison,
                                 input bit wv, input logic [9:0] wa, input logic [31:0] wd);
        resp_t  obs;
        resp_t  nr;
        bit     nv;
        bit     exp_yumi;
        longint pa;
        int     idx;
        fe_if.mem_cmd_v = cv;   fe_if.mem_cmd_op = op;  fe_if.mem_cmd_vaddr = va;
        fe_if.mem_cmd_vtag = vt; fe_if.mem_cmd_ptag = pt; fe_if.mem_cmd_u = u; fe_if.mem_cmd_x = x;
        fe_if.mem_priv = pr; fe_if.mem_translation_en = tr; fe_if.mem_poison = poison;
        fe_if.mem_w_v = wv; fe_if.mem_w_addr = wa; fe_if.mem_w_data = wd;
        checkOutput("resp_v", 64'(fe_if.mem_resp_v), 64'(s2v));
        if (s2v) begin
            obs = {fe_if.resp_data, fe_if.resp_icache_miss, fe_if.resp_itlb_miss,
                   fe_if.resp_access_fault, fe_if.resp_page_fault};
            checkOutput("resp", 64'(obs), 64'(s2r));
        end
        #1;
        exp_yumi = cv && !(cycle >= miss_start && cycle <= miss_end);
        checkOutput("yumi", 64'(fe_if.mem_cmd_yumi), 64'(exp_yumi));
        nv = 0; nr = '0; pa = 0;
        if (s1v && !poison) begin
            nv = 1;
            if (s1tr) begin
                idx = tlbFind(s1va[38:12]);
                if (idx < 0) nr.itlbm = 1'b1;
                else begin
                    pa = longint'({tpt[idx], s1va[11:0]});
                    if (!tx[idx] || (s1pr == PRIV_U && !tu[idx]) || (s1pr == PRIV_S && tu[idx])) nr.pf = 1'b1;
                end
            end else begin
                pa = longint'(s1va);
            end
            if (!nr.itlbm && !nr.pf && pa >= 4 * MEMW) nr.af = 1'b1;
            if (!nr.itlbm && !nr.pf && !nr.af) begin
                if (clean_cnt == MISSP - 1) begin
                    nr.icm = 1'b1; clean_cnt = 0;
                    miss_start = cycle + 1; miss_end = cycle + MISSL;
                end else begin
                    nr.data = mem_m[(pa / 4) % MEMW];
                    clean_cnt++;
                end
            end
        end
        if (wv) mem_m[wa] = wd;
        s1v = exp_yumi && op == OP_FETCH;
        if (s1v) begin s1va = va; s1pr = pr; s1tr = tr; end
        if (exp_yumi && op == OP_FILL) modelFill(vt, pt, u, x);
        if (exp_yumi && op == OP_FENCE) for (int i = 0; i < ELS; i++) tv[i] = 1'b0;
        s2v = nv; s2r = nr;
        @(posedge clk); #1;
        cycle++;
    endtask

    task automatic idleCycle();
        applyStimulus(0, OP_FETCH, '0, '0, '0, 0, 0, 2'd3, 0, 0, 0, '0, '0);
    endtask

    task automatic fetchCycle(input logic [38:0] va, input logic [1:0] pr, input bit tr, input bit poison);
        applyStimulus(1, OP_FETCH, va, '0, '0, 0, 0, pr, tr, poison, 0, '0, '0);
    endtask

    task automatic fillCycle(input logic [26:0] vt, input logic [27:0] pt, input bit u, input bit x);
        applyStimulus(1, OP_FILL, '0, vt, pt, u, x, 2'd3, 0, 0, 0, '0, '0);
    endtask

    task automatic doReset();
        fe_if.mem_cmd_v = 1'b1;
        rst = 1'b1;
        #1;
        checkOutput("yumi_in_reset", 64'(fe_if.mem_cmd_yumi), 64'd0);
        @(posedge clk); #1;
        checkOutput("reset_resp_v", 64'(fe_if.mem_resp_v), 64'd0);
        checkOutput("reset_resp", 64'({fe_if.resp_data, fe_if.resp_icache_miss, fe_if.resp_itlb_miss,
                                       fe_if.resp_access_fault, fe_if.resp_page_fault}), 64'd0);
        fe_if.mem_cmd_v = 1'b0;
        rst = 1'b0;
        modelClear();
        cycle++;
    endtask

    initial begin
        logic [26:0] vt;
        logic [11:0] off;
        logic [38:0] va;
        logic [1:0]  pr;
        bit          tr;
        int          opsel;
        bit          in_window;
        cycle = 0;
        rst = 1'b1;
        fe_if.mem_cmd_v = 0; fe_if.mem_cmd_op = '0; fe_if.mem_cmd_vaddr = '0; fe_if.mem_cmd_vtag = '0;
        fe_if.mem_cmd_ptag = '0; fe_if.mem_cmd_u = 0; fe_if.mem_cmd_x = 0; fe_if.mem_priv = '0;
        fe_if.mem_translation_en = 0; fe_if.mem_poison = 0; fe_if.mem_w_v = 0;
        fe_if.mem_w_addr = '0; fe_if.mem_w_data = '0;
        modelClear();
        doReset();

        for (int i = 0; i < MEMW; i++) begin
            applyStimulus(0, OP_FETCH, '0, '0, '0, 0, 0, 2'd3, 0, 0, 1, 10'(i), (i == 4) ? 32'h13 : $urandom);
        end

        // Plain fetch with translation off.
        doReset();
        fetchCycle(39'h10, 2'd3, 0, 0);
        idleCycle();
        checkOutput("t1_resp_v", 64'(fe_if.mem_resp_v), 64'd1);
        checkOutput("t1_data", 64'(fe_if.resp_data), 64'h13);

        // ITLB miss, fill, refetch hit.
        fetchCycle(39'h8000_0000, PRIV_S, 1, 0);
        idleCycle();
        checkOutput("t2_itlb_miss", 64'(fe_if.resp_itlb_miss), 64'd1);
        fillCycle(27'h80000, 28'h0, 0, 1);
        fetchCycle(39'h8000_0000, PRIV_S, 1, 0);
        idleCycle();
        idleCycle();

        // Poison on the middle of three back-to-back fetches.
        fetchCycle(39'h0, 2'd3, 0, 0);
        fetchCycle(39'h4, 2'd3, 0, 0);
        fetchCycle(39'h8, 2'd3, 0, 1);
        idleCycle();
        idleCycle();
        idleCycle();

        // Round-robin replacement after the ITLB fills up, then fence.
        doReset();
        for (int i = 0; i < 9; i++) fillCycle(27'h100 + 27'(i), 28'h0, 0, 1);
        fetchCycle({27'h100, 12'h0}, PRIV_S, 1, 0);
        idleCycle();
        checkOutput("t6_victim_evicted", 64'(fe_if.resp_itlb_miss), 64'd1);
        applyStimulus(1, OP_FENCE, '0, '0, '0, 0, 0, 2'd3, 0, 0, 0, '0, '0);
        fetchCycle({27'h108, 12'h0}, PRIV_S, 1, 0);
        idleCycle();
        checkOutput("t6_fence_miss", 64'(fe_if.resp_itlb_miss), 64'd1);

        for (int n = 0; n < 3000; n++) begin
            opsel = int'($urandom % 30);
            vt    = 27'h80000 + 27'($urandom % 10);
            off   = 12'($urandom % 1024) << 2;
            tr    = ($urandom % 4) != 0;
            va    = tr ? {vt, off} : 39'(($urandom % 1280) * 4);
            pr    = 2'($urandom % 3);
            if (pr == 2'd2) pr = 2'd3;
            applyStimulus(($urandom % 4) != 0,
                          (opsel < 22) ? OP_FETCH : (opsel < 29) ? OP_FILL : OP_FENCE,
                          va, vt, 28'(($urandom % 8) == 0), 1'($urandom), ($urandom % 6) != 0,
                          pr, tr, ($urandom % 8) == 0,
                          ($urandom % 8) == 0, 10'($urandom), $urandom);
        end

        // Reset while stalled on an injected miss.
        in_window = 0;
        for (int n = 0; n < 12 && !in_window; n++) begin
            fetchCycle(39'h0, 2'd3, 0, 0);
            in_window = (cycle >= miss_start && cycle <= miss_end);
        end
        checkOutput("miss_window_reached", 64'(in_window), 64'd1);
        doReset();
        fetchCycle(39'h0, 2'd3, 0, 0);
        idleCycle();
        idleCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
